// File: rtl/lcd12864_pkg.sv
// rtl/lcd12864_pkg.sv - shared states, LCD command bytes, default timing and init helpers
package lcd12864_pkg;

  typedef enum logic [2:0] {
    ST_RST_LO   = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_INIT     = 3'd2,
    ST_IDLE     = 3'd3,
    ST_SETUP    = 3'd4,
    ST_EN_HI    = 3'd5,
    ST_EXEC     = 3'd6
  } state_t;

  // ST7920 basic instruction set commands
  localparam logic [7:0] CMD_BASIC   = 8'h30;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;

  // DDRAM start address of each text row
  localparam logic [7:0] ROW0 = 8'h80;
  localparam logic [7:0] ROW1 = 8'h90;
  localparam logic [7:0] ROW2 = 8'h88;
  localparam logic [7:0] ROW3 = 8'h98;

  // Default cycle counts for the 50 MHz board clock
  localparam int SETUP_CYC_DEF = 2;
  localparam int EN_CYC_DEF    = 12;
  localparam int EXEC_CYC_DEF  = 3600;
  localparam int CLR_CYC_DEF   = 80000;
  localparam int RST_CYC_DEF   = 50000;
  localparam int PWR_CYC_DEF   = 2000000;

  // Number of bytes in the built-in controller init sequence
  localparam int INIT_LEN = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The clear command needs the long execution wait
  function automatic logic is_clear(input logic rs, input logic [7:0] data);
    return (!rs) && (data == CMD_CLEAR);
  endfunction

  // Controller init sequence, all sent with rs=0
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_BASIC;
      3'd1:    return CMD_BASIC;
      3'd2:    return CMD_DISP_ON;
      3'd3:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd12864_delay_cnt.sv
// rtl/lcd12864_delay_cnt.sv - loadable down-counter with zero flag for LCD bus timing
module lcd12864_delay_cnt #(
  parameter int              W         = 8,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load wins; otherwise count down and park at zero so the counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd12864_bus_writer.sv
// rtl/lcd12864_bus_writer.sv - ST7920 8-bit parallel byte writer; optional init sequence via LCD12864_INIT_SEQ_EN
module lcd12864_bus_writer
  import lcd12864_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int EN_CYC    = EN_CYC_DEF,
  parameter int EXEC_CYC  = EXEC_CYC_DEF,
  parameter int CLR_CYC   = CLR_CYC_DEF,
  parameter int RST_CYC   = RST_CYC_DEF,
  parameter int PWR_CYC   = PWR_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       lcd_rst,
  output logic       lcd_psb
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_CYC), max_int(EXEC_CYC, CLR_CYC)),
                                   max_int(RST_CYC, PWR_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // A state that lasts N edges loads N-1 on its entry edge and leaves on the edge that sees zero
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(PWR_CYC - 1);

  state_t             state;
  logic               accept;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_done;

`ifdef LCD12864_INIT_SEQ_EN
  logic [2:0]         init_idx;
`endif

  assign accept  = in_valid && in_ready;
  assign lcd_rw  = 1'b0;
  assign lcd_psb = 1'b1;

  // Starts in reset preloaded with the lcd_rst low time so RST_LO needs no entry edge
  lcd12864_delay_cnt #(
    .W         (CNT_W),
    .RESET_VAL (LD_RST)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Reload the shared delay counter on every state transition with the next state's length
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_RST_LO: begin
        cnt_load = cnt_done;
        cnt_val  = LD_PWR;
      end
      ST_PWR_WAIT: begin
        cnt_load = cnt_done;
        cnt_val  = LD_SETUP;
      end
      ST_IDLE: begin
        cnt_load = accept;
        cnt_val  = LD_SETUP;
      end
      ST_INIT, ST_SETUP: begin
        cnt_load = cnt_done;
        cnt_val  = LD_EN;
      end
      ST_EN_HI: begin
        cnt_load = cnt_done;
        cnt_val  = is_clear(lcd_rs, lcd_dat) ? LD_CLR : LD_EXEC;
      end
      ST_EXEC: begin
        cnt_load = cnt_done;
        cnt_val  = LD_SETUP;
      end
      default: begin
        cnt_load = 1'b0;
        cnt_val  = '0;
      end
    endcase
  end

  // Bus sequencing FSM; all LCD-side outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST_LO;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_dat   <= 8'h00;
      lcd_rst   <= 1'b0;
`ifdef LCD12864_INIT_SEQ_EN
      init_idx  <= 3'd0;
`endif
    end else begin
      case (state)
        ST_RST_LO: begin
          if (cnt_done) begin
            lcd_rst <= 1'b1;
            state   <= ST_PWR_WAIT;
          end
        end

        ST_PWR_WAIT: begin
          if (cnt_done) begin
`ifdef LCD12864_INIT_SEQ_EN
            // First init byte is latched here; INIT then plays the role of SETUP
            lcd_rs   <= 1'b0;
            lcd_dat  <= init_byte(3'd0);
            init_idx <= 3'd1;
            state    <= ST_INIT;
`else
            in_ready  <= 1'b1;
            init_done <= 1'b1;
            state     <= ST_IDLE;
`endif
          end
        end

        ST_IDLE: begin
          if (accept) begin
            lcd_rs   <= in_rs;
            lcd_dat  <= in_data;
            in_ready <= 1'b0;
            state    <= ST_SETUP;
          end
        end

        ST_INIT, ST_SETUP: begin
          if (cnt_done) begin
            lcd_en <= 1'b1;
            state  <= ST_EN_HI;
          end
        end

        ST_EN_HI: begin
          if (cnt_done) begin
            lcd_en <= 1'b0;
            state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (cnt_done) begin
`ifdef LCD12864_INIT_SEQ_EN
            // Before init_done every EXEC belongs to the init sequence
            if (!init_done && (init_idx != 3'(INIT_LEN))) begin
              lcd_rs   <= 1'b0;
              lcd_dat  <= init_byte(init_idx);
              init_idx <= init_idx + 3'd1;
              state    <= ST_INIT;
            end else begin
              in_ready  <= 1'b1;
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end
`else
            in_ready <= 1'b1;
            state    <= ST_IDLE;
`endif
          end
        end

        default: begin
          state <= ST_RST_LO;
        end
      endcase
    end
  end

endmodule
